// File: rtl/bsg_cache_to_dram_ctrl_cmd_sched.sv
// ---------------------------------------------------------------------------
// bsg_cache_to_dram_ctrl_cmd_sched
//
// Command-side scheduler for the cache-to-DRAM-controller bridge. Picks one
// cache DMA packet at a time with round-robin priority and breaks it into
// block_size_in_words_p/dram_ctrl_burst_len_p DRAM controller commands.
// Each accepted command also pushes the owning cache's tag into the tx tag
// FIFO (write-backs) or the rx tag FIFO (fills). The data-path blocks use
// these tags to steer the data.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   dma_pkt_v_i           per-cache packet valid
//   dma_pkt_write_i       per-cache direction (1 = write-back, 0 = fill)
//   dma_pkt_addr_i        per-cache byte address, cache i in slice i
//   dma_pkt_yumi_o        one-hot packet accept
//   app_en_o/app_cmd_o    DRAM command valid / opcode (000 wr, 001 rd)
//   app_addr_o            DRAM word address
//   app_rdy_i             DRAM command ready
//   tx_v_o/tx_tag_o       write-tag enqueue, tx_ready_i its ready
//   rx_v_o/rx_tag_o       read-tag enqueue, rx_ready_i its ready
// ---------------------------------------------------------------------------
module bsg_cache_to_dram_ctrl_cmd_sched #(
  parameter int num_cache_p           = 2,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int dram_ctrl_burst_len_p = 1,
  parameter int dram_addr_width_p     = 28,
  localparam int tag_w = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,

  input  logic [num_cache_p-1:0]              dma_pkt_v_i,
  input  logic [num_cache_p-1:0]              dma_pkt_write_i,
  input  logic [num_cache_p*addr_width_p-1:0] dma_pkt_addr_i,
  output logic [num_cache_p-1:0]              dma_pkt_yumi_o,

  output logic                                app_en_o,
  output logic [2:0]                          app_cmd_o,
  output logic [dram_addr_width_p-1:0]        app_addr_o,
  input  logic                                app_rdy_i,

  output logic                                tx_v_o,
  output logic [tag_w-1:0]                    tx_tag_o,
  input  logic                                tx_ready_i,

  output logic                                rx_v_o,
  output logic [tag_w-1:0]                    rx_tag_o,
  input  logic                                rx_ready_i
);

  localparam int nCmd  = block_size_in_words_p / dram_ctrl_burst_len_p;
  localparam int lgWb  = $clog2(data_width_p / 8);
  localparam int lgBlk = $clog2(block_size_in_words_p);
  localparam int cntW  = (nCmd > 1) ? $clog2(nCmd) : 1;

  localparam logic [cntW-1:0]              lastCnt = cntW'(nCmd - 1);
  localparam logic [dram_addr_width_p-1:0] burstW  = dram_addr_width_p'(dram_ctrl_burst_len_p);
  localparam logic [tag_w-1:0]             rrInit  = tag_w'(num_cache_p - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e                        state_q, state_d;
  logic [cntW-1:0]               cmdCnt_q, cmdCnt_d;
  logic [tag_w-1:0]              rrLast_q, rrLast_d;
  logic [tag_w-1:0]              tag_q, tag_d;
  logic                          wr_q, wr_d;
  logic [dram_addr_width_p-1:0]  base_q, base_d;

  logic                          grantFound;
  logic [tag_w-1:0]              grantIdx;
  logic                          grantWrite;
  logic [addr_width_p-1:0]       grantAddr;
  logic [addr_width_p-1:0]       wordAddr;
  logic [addr_width_p-1:0]       blockAddr;
  logic                          cmdAccept;

  // Round-robin pick: the first valid cache strictly above the last winner
  // wins; if there is none, the lowest valid cache wins (the wrap-around).
  // The winner's direction and address are selected here as well, so the
  // FSM only has to latch them.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    grantWrite = 1'b0;
    grantAddr  = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      if (!grantFound && dma_pkt_v_i[i] && (i > int'(rrLast_q))) begin
        grantFound = 1'b1;
        grantIdx   = tag_w'(i);
      end
    end
    for (int i = 0; i < num_cache_p; i++) begin
      if (!grantFound && dma_pkt_v_i[i]) begin
        grantFound = 1'b1;
        grantIdx   = tag_w'(i);
      end
    end
    for (int i = 0; i < num_cache_p; i++) begin
      if (grantIdx == tag_w'(i)) begin
        grantWrite = dma_pkt_write_i[i];
        grantAddr  = dma_pkt_addr_i[i*addr_width_p +: addr_width_p];
      end
    end
  end

  // Byte address to word address, then clear the in-block word offset so
  // the command sequence always starts at the beginning of the block.
  always_comb begin
    wordAddr  = grantAddr >> lgWb;
    blockAddr = (wordAddr >> lgBlk) << lgBlk;
  end

  // All scheduler state lives here; everything is cleared asynchronously
  // so a reset mid-packet drops the remaining commands at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cmdCnt_q <= '0;
      rrLast_q <= rrInit;
      tag_q    <= '0;
      wr_q     <= 1'b0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmdCnt_q <= cmdCnt_d;
      rrLast_q <= rrLast_d;
      tag_q    <= tag_d;
      wr_q     <= wr_d;
      base_q   <= base_d;
    end
  end

  // Next-state and handshake logic. In IDLE a packet is accepted in the same
  // cycle it is seen. In ISSUE a command is offered only when the matching
  // tag FIFO has room, so the tag push and the command accept coincide.
  always_comb begin
    state_d        = state_q;
    cmdCnt_d       = cmdCnt_q;
    rrLast_d       = rrLast_q;
    tag_d          = tag_q;
    wr_d           = wr_q;
    base_d         = base_q;
    dma_pkt_yumi_o = '0;
    app_en_o       = 1'b0;
    tx_v_o         = 1'b0;
    rx_v_o         = 1'b0;
    cmdAccept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grantFound && !reset_i) begin
          for (int i = 0; i < num_cache_p; i++) begin
            if (grantIdx == tag_w'(i)) begin
              dma_pkt_yumi_o[i] = 1'b1;
            end
          end
          tag_d    = grantIdx;
          wr_d     = grantWrite;
          base_d   = dram_addr_width_p'(blockAddr);
          rrLast_d = grantIdx;
          cmdCnt_d = '0;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        app_en_o  = wr_q ? tx_ready_i : rx_ready_i;
        cmdAccept = app_en_o && app_rdy_i;
        if (cmdAccept) begin
          tx_v_o = wr_q;
          rx_v_o = !wr_q;
          if (cmdCnt_q == lastCnt) begin
            cmdCnt_d = '0;
            state_d  = IDLE;
          end else begin
            cmdCnt_d = cmdCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command fields come only from registers, so they hold steady while a
  // command waits for app_rdy_i.
  always_comb begin
    app_cmd_o  = wr_q ? 3'b000 : 3'b001;
    app_addr_o = base_q + (dram_addr_width_p'(cmdCnt_q) * burstW);
    tx_tag_o   = tag_q;
    rx_tag_o   = tag_q;
  end

endmodule
